// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle RV32I control unit. Steps each instruction through
//   FETCH / DECODE / EXECUTE / MEM / WB. MEM_LAT adds wait cycles to
//   every memory access, so FETCH, MEMREAD and MEMWRITE each last
//   MEM_LAT+1 cycles. Supports lw, sw, R-type, I-type ALU, beq and jal.
//   Any other opcode parks the FSM in TRAP with the sticky illegal flag
//   set until reset.
//
// Parameters
//   MEM_LAT  extra wait cycles per memory access
//   CNT_W    wait-counter width (2**CNT_W must exceed MEM_LAT)
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   Op          opcode field of the current IR
//   zero        ALU zero flag (beq decision)
//   PCWrite     PC enable         AdrSrc    0=PC, 1=ALUOut
//   MemWrite    store strobe      IRWrite   IR / OldPC enable
//   ResultSrc   00=ALUOut 01=Data 10=ALUResult
//   ALUSrcA     00=PC 01=OldPC 10=RD1
//   ALUSrcB     00=RD2 01=Imm 10=4
//   ALUOp       00=add 01=sub 10=funct
//   ImmSrc      00=I 01=S 10=B 11=J
//   RegWrite    register-file write enable
//   illegal     sticky illegal-opcode flag
//   state       current FSM state
module multicycle_controller #(
   parameter int unsigned MEM_LAT = 0,
   parameter int unsigned CNT_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic             done;
   logic             mem_state;
   logic             pc_update;
   logic             branch;
   logic             ir_write;
   logic             mem_write;
   logic             reg_write;

   assign done      = (cnt == LAT);
   assign mem_state = (cur == FETCH) || (cur == MEMREAD) || (cur == MEMWRITE);

   // Counter restarts on every state change, so each memory state
   // begins its wait from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= FETCH;
         cnt     <= '0;
         illegal <= 1'b0;
      end else begin
         cur <= nxt;
         if (nxt != cur) begin
            cnt <= '0;
         end else if (mem_state) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (nxt == TRAP) begin
            illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      nxt       = cur;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      case (cur)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (done) begin
               ir_write  = 1'b1;
               pc_update = 1'b1;
               nxt       = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (Op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_R:         nxt = EXECR;
               OP_I:         nxt = EXECI;
               OP_BEQ:       nxt = BEQ;
               OP_JAL:       nxt = JAL;
               default:      nxt = TRAP;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            nxt     = (Op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (done) nxt = MEMWB;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            // Strobe only in the final wait cycle: one write per store.
            if (done) begin
               mem_write = 1'b1;
               nxt       = FETCH;
            end
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
            nxt       = FETCH;
         end
         EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            nxt     = ALUWB;
         end
         EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            nxt     = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            nxt       = FETCH;
         end
         BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
            nxt     = FETCH;
         end
         JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            nxt       = ALUWB;
         end
         TRAP:    nxt = TRAP;
         default: nxt = FETCH;
      endcase
   end

   // Reset gates every write strobe combinationally, so an aborted
   // instruction cannot commit anything in the reset cycle.
   assign PCWrite  = ~rst & (pc_update | (branch & zero));
   assign IRWrite  = ~rst & ir_write;
   assign MemWrite = ~rst & mem_write;
   assign RegWrite = ~rst & reg_write;

   assign ImmSrc = (Op == OP_SW)  ? 2'b01 :
                   (Op == OP_BEQ) ? 2'b10 :
                   (Op == OP_JAL) ? 2'b11 : 2'b00;

   assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Three controllers (MEM_LAT = 0, 1, 2) share op/zero; only the active
//   one is out of reset. A phase-list model predicts each cycle's state
//   and outputs; per-instruction literals pin lengths and strobe counts.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                          S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                          S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                          S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

   typedef struct packed {
      logic [3:0] st;
      logic       done;
   } step_t;

   typedef struct packed {
      logic       pcw, adr, memw, irw;
      logic [1:0] rs, sa, sb, aop, imm;
      logic       regw, ill;
      logic [3:0] st;
   } out_t;

   logic       clk = 1'b0;
   logic       rst_a [3];
   logic [6:0] op;
   logic       zero;
   logic       pcw [3], adr [3], memw [3], irw [3], regw [3], ill [3];
   logic [1:0] rsrc [3], srca [3], srcb [3], aop [3], imm [3];
   logic [3:0] st [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      multicycle_controller #(.MEM_LAT(g), .CNT_W(4)) dut (
         .clk(clk), .rst(rst_a[g]), .Op(op), .zero(zero),
         .PCWrite(pcw[g]), .AdrSrc(adr[g]), .MemWrite(memw[g]), .IRWrite(irw[g]),
         .ResultSrc(rsrc[g]), .ALUSrcA(srca[g]), .ALUSrcB(srcb[g]), .ALUOp(aop[g]),
         .ImmSrc(imm[g]), .RegWrite(regw[g]), .illegal(ill[g]), .state(st[g])
      );
   end

   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_bad = 0;
   int    act = 0;
   bit    chk_on = 0;
   step_t cur;
   step_t fut [$];
   logic  m_ill = 1'b0;
   int    last_irw_at, last_memw_at, n_irw_last;
   logic  last_memw_adr;
   logic [1:0] last_memw_imm;

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s (MEM_LAT=%0d, t=%0t): got %0h, expected %0h", nm, act, $time, got, exp);
      end
   endfunction

   // Push a phase lasting n cycles; the last cycle is the "done" one.
   function automatic void push_phase(input logic [3:0] s, input int n);
      step_t x;
      for (int i = 0; i < n; i++) begin
         x.st   = s;
         x.done = (i == n - 1);
         fut.push_back(x);
      end
   endfunction

   function automatic void push_fetch();
      push_phase(S_FETCH, act + 1);
      push_phase(S_DECODE, 1);
   endfunction

   function automatic void push_tail(input logic [6:0] o);
      case (o)
         OP_LW:  begin push_phase(S_MEMADR, 1); push_phase(S_MEMREAD, act + 1); push_phase(S_MEMWB, 1); end
         OP_SW:  begin push_phase(S_MEMADR, 1); push_phase(S_MEMWRITE, act + 1); end
         OP_R:   begin push_phase(S_EXECR, 1); push_phase(S_ALUWB, 1); end
         OP_I:   begin push_phase(S_EXECI, 1); push_phase(S_ALUWB, 1); end
         OP_BEQ: push_phase(S_BEQ, 1);
         OP_JAL: begin push_phase(S_JAL, 1); push_phase(S_ALUWB, 1); end
         default: push_phase(S_TRAP, 1);
      endcase
   endfunction

   // Advance the model across one clock edge, given the inputs of the cycle before it.
   function automatic void model_tick(input logic r, input logic [6:0] o);
      if (r) begin
         fut.delete();
         m_ill = 1'b0;
         push_fetch();
         cur = fut.pop_front();
         return;
      end
      if (cur.st == S_DECODE) push_tail(o);
      if (fut.size() != 0) begin
         cur = fut.pop_front();
      end else if (cur.st != S_TRAP) begin
         push_fetch();
         cur = fut.pop_front();
      end
      if (cur.st == S_TRAP) m_ill = 1'b1;
   endfunction

   function automatic out_t model_out(input step_t s, input logic [6:0] o, input logic z,
                                      input logic r, input logic il);
      out_t e;
      e = '0;
      e.st  = s.st;
      e.ill = il;
      case (s.st)
         S_FETCH:    begin e.sb = 2'b10; e.rs = 2'b10; e.irw = s.done; e.pcw = s.done; end
         S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
         S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
         S_MEMREAD:  e.adr = 1'b1;
         S_MEMWRITE: begin e.adr = 1'b1; e.memw = s.done; end
         S_MEMWB:    begin e.rs = 2'b01; e.regw = 1'b1; end
         S_EXECR:    begin e.sa = 2'b10; e.aop = 2'b10; end
         S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
         S_ALUWB:    e.regw = 1'b1;
         S_BEQ:      begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
         S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
         default:    ;
      endcase
      e.imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
      if (r) begin
         e.pcw = 1'b0; e.irw = 1'b0; e.memw = 1'b0; e.regw = 1'b0;
      end
      return e;
   endfunction

   task automatic compare_cycle();
      out_t e;
      if (!chk_on) return;
      e = model_out(cur, op, zero, rst_a[act], m_ill);
      chk("state", st[act], e.st);
      chk("PCWrite", pcw[act], e.pcw);
      chk("AdrSrc", adr[act], e.adr);
      chk("MemWrite", memw[act], e.memw);
      chk("IRWrite", irw[act], e.irw);
      chk("ResultSrc", rsrc[act], e.rs);
      chk("ALUSrcA", srca[act], e.sa);
      chk("ALUSrcB", srcb[act], e.sb);
      chk("ALUOp", aop[act], e.aop);
      chk("ImmSrc", imm[act], e.imm);
      chk("RegWrite", regw[act], e.regw);
      chk("illegal", ill[act], e.ill);
      for (int k = 0; k < 3; k++) begin
         if (k != act) chk("held_in_reset_wen", {pcw[k], irw[k], memw[k], regw[k]}, 0);
      end
   endtask

   task automatic tick(input logic r);
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
      model_tick(rst_a[act], op);
      rst_a[act] = r;
   endtask

   // Leaves the selected instance in its first FETCH cycle after a 2-cycle reset.
   task automatic start(input int k);
      for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
      chk_on = 0;
      act = k;
      tick(1'b1);
      chk_on = 1;
      tick(1'b0);
   endtask

   // Runs one instruction from its first FETCH cycle to the next instruction's first FETCH cycle.
   task automatic run_instr(input string nm, input logic [6:0] o, input logic z, input int e_len,
                            input logic [63:0] e_tr, input int e_pcw, input int e_regw, input int e_memw);
      int n, n_pcw, n_regw, n_memw;
      logic [63:0] tr;
      logic [3:0] prev;
      bit ended;
      op = o;
      zero = z;
      #1;
      n = 0; n_pcw = 0; n_regw = 0; n_memw = 0; n_irw_last = 0; tr = '0; ended = 0;
      last_irw_at = 0; last_memw_at = 0; last_memw_adr = 1'b0; last_memw_imm = 2'b00;
      for (int i = 0; i < 40 && !ended; i++) begin
         if (i > 0) begin
            prev = st[act];
            tick(1'b0);
            #1;
            if (st[act] == S_FETCH && prev != S_FETCH) ended = 1;
         end
         if (!ended) begin
            n++;
            tr = {tr[59:0], st[act]};
            n_pcw += int'(pcw[act]);
            n_regw += int'(regw[act]);
            n_memw += int'(memw[act]);
            if (irw[act]) begin n_irw_last++; last_irw_at = n; end
            if (memw[act]) begin
               last_memw_at = n; last_memw_adr = adr[act]; last_memw_imm = imm[act];
            end
         end
      end
      chk({nm, "_completed"}, ended, 1);
      chk({nm, "_cycles"}, n, e_len);
      chk({nm, "_state_trace"}, tr, e_tr);
      chk({nm, "_pcwrite_count"}, n_pcw, e_pcw);
      chk({nm, "_regwrite_count"}, n_regw, e_regw);
      chk({nm, "_memwrite_count"}, n_memw, e_memw);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
      op = OP_R;
      zero = 1'b0;

      // MEM_LAT = 0
      start(0);
      chk("reset_state", st[0], S_FETCH);
      chk("reset_illegal", ill[0], 0);
      run_instr("r_l0",    OP_R,   1'b0, 4, 64'h0168, 1, 1, 0);
      run_instr("i_l0",    OP_I,   1'b0, 4, 64'h0178, 1, 1, 0);
      run_instr("jal_l0",  OP_JAL, 1'b0, 4, 64'h01A8, 2, 1, 0);
      run_instr("beq1_l0", OP_BEQ, 1'b1, 3, 64'h019,  2, 0, 0);
      run_instr("beq0_l0", OP_BEQ, 1'b0, 3, 64'h019,  1, 0, 0);
      run_instr("lw_l0",   OP_LW,  1'b0, 5, 64'h01234, 1, 1, 0);
      run_instr("sw_l0",   OP_SW,  1'b0, 4, 64'h0125, 1, 0, 1);

      // Illegal opcode: trap, hold, then recover through reset.
      op = OP_BAD;
      zero = 1'b0;
      for (int i = 0; i < 10 && st[act] != S_TRAP; i++) begin tick(1'b0); #1; end
      chk("trap_entry_state", st[act], S_TRAP);
      chk("trap_entry_illegal", ill[act], 1);
      repeat (10) begin
         tick(1'b0);
         #1;
         chk("trap_hold_illegal", ill[act], 1);
         chk("trap_hold_wen", {pcw[act], irw[act], memw[act], regw[act]}, 0);
      end
      tick(1'b1);
      #1;
      chk("trap_rst_cycle_wen", {pcw[act], irw[act], memw[act], regw[act]}, 0);
      tick(1'b0);
      #1;
      chk("trap_exit_state", st[act], S_FETCH);
      chk("trap_exit_illegal", ill[act], 0);
      run_instr("r_after_trap", OP_R, 1'b0, 4, 64'h0168, 1, 1, 0);

      // MEM_LAT = 1
      start(1);
      run_instr("sw_l1", OP_SW, 1'b0, 6, 64'h001255, 1, 0, 1);
      chk("sw_l1_strobe_cycle", last_memw_at, 6);
      chk("sw_l1_strobe_adrsrc", last_memw_adr, 1);
      chk("sw_l1_strobe_immsrc", last_memw_imm, 2'b01);
      run_instr("beq1_l1", OP_BEQ, 1'b1, 4, 64'h0019, 2, 0, 0);

      // Reset landing on the MEMWRITE done cycle aborts the store.
      op = OP_SW;
      zero = 1'b0;
      for (int i = 0; i < 20 && !(cur.st == S_MEMWRITE && cur.done); i++) tick(1'b0);
      rst_a[act] = 1'b1;
      #1;
      chk("rst_memwrite_state", st[act], S_MEMWRITE);
      chk("rst_memwrite_strobe", memw[act], 0);
      tick(1'b0);
      #1;
      chk("rst_memwrite_next_state", st[act], S_FETCH);
      run_instr("r_after_rst_l1", OP_R, 1'b0, 5, 64'h00168, 1, 1, 0);

      // MEM_LAT = 2
      start(2);
      run_instr("lw_l2", OP_LW, 1'b0, 9, 64'h000123334, 1, 1, 0);
      chk("lw_l2_irwrite_count", n_irw_last, 1);
      chk("lw_l2_irwrite_cycle", last_irw_at, 3);
      run_instr("jal_l2", OP_JAL, 1'b0, 6, 64'h0001A8, 2, 1, 0);
      run_instr("sw_l2",  OP_SW,  1'b0, 8, 64'h00012555, 1, 0, 1);
      chk("sw_l2_strobe_cycle", last_memw_at, 8);

      tick(1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: run did not finish within the time limit");
      $fatal(1, "watchdog");
   end

endmodule
